// File: rtl/req_ack_pkg.sv
// req_ack_pkg: shared FSM state type and default parameters for req_ack_arbiter
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/req_ack_arbiter_rr_pick.sv
// rr_pick: masked priority encoder, lowest masked request wins, else lowest request
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [N-1:0]  reqs,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [N-1:0] masked;

    always_comb begin
        masked = reqs & mask;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (reqs[i]) idx = IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) idx = IW'(i);
        end
        valid = |reqs;
    end

endmodule

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin arbiter driving a four-phase req/ack channel with timeout
module req_ack_arbiter
    import req_ack_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_done,
    output logic [NUM_SRC-1:0]        src_err,
    output logic                      req,
    input  logic                      ack,
    output logic [DATA_W-1:0]         data,
    output logic                      busy
);

    localparam int IW = $clog2(NUM_SRC);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [IW-1:0]      last_grant, owner, pick;
    logic [NUM_SRC-1:0] mask, owner_bit;
    logic               pick_ok, timed_out, waiting;

    // sources strictly above the last grant get first chance
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_SRC; i++) mask[i] = i > int'(last_grant);
    end

    rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .mask  (mask),
        .reqs  (src_valid),
        .idx   (pick),
        .valid (pick_ok)
    );

    assign timed_out = cnt == CNT_W'(TIMEOUT);
    assign waiting   = state == REQ_HI || state == REQ_LO;
    assign owner_bit = NUM_SRC'(1) << owner;
    assign busy      = state != IDLE;

    // an ack edge beats a timeout reached on the same edge
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = pick_ok ? REQ_HI : IDLE;
            REQ_HI:  state_n = ack ? REQ_LO : timed_out ? ABORT : REQ_HI;
            REQ_LO:  state_n = !ack ? IDLE : timed_out ? ABORT : REQ_LO;
            ABORT:   state_n = !ack ? IDLE : ABORT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req        <= 1'b0;
            data       <= '0;
            src_done   <= '0;
            src_err    <= '0;
            cnt        <= '0;
            owner      <= '0;
            last_grant <= IW'(NUM_SRC - 1);
        end else begin
            state    <= state_n;
            req      <= state_n == REQ_HI;
            cnt      <= (state_n != state || !waiting) ? '0 : cnt + CNT_W'(1);
            src_done <= (state == REQ_LO && state_n == IDLE) ? owner_bit : '0;
            src_err  <= (state == ABORT && state_n == IDLE) ? owner_bit : '0;
            if (state == IDLE && pick_ok) begin
                owner      <= pick;
                last_grant <= pick;
                data       <= src_data[int'(pick)*DATA_W +: DATA_W];
            end
        end
    end

    a_pulse_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(src_done | src_err) && !(|src_done && |src_err));
    a_req_busy: assert property (@(posedge clk) disable iff (rst) req |-> busy);

endmodule

// File: tb/tb_req_ack_arbiter.sv
// tb_req_ack_arbiter: randomized transaction-level check of req_ack_arbiter
module tb_req_ack_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_valid = '0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_done, src_err;
    logic           req;
    logic           ack = 1'b0;
    logic [W-1:0]   data;
    logic           busy;

    logic [N-1:0] vmask = '0;
    logic [W-1:0] src_d [N];
    int           last_m = N - 1;
    int           n_cmp = 0;
    int           n_bad = 0;

    req_ack_arbiter #(.NUM_SRC(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_done  (src_done),
        .src_err   (src_err),
        .req       (req),
        .ack       (ack),
        .data      (data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        return N'(1) << w;
    endfunction

    task automatic drive();
        src_valid = vmask;
        for (int i = 0; i < N; i++) src_data[i*W +: W] = src_d[i];
    endtask

    // one arbitration round: the model predicts owner, req width, pulse cycle and kind
    task automatic run_txn(input logic [N-1:0] add, input int rise, input int fall,
                           input bit mutate, input bit keep);
        int who, exp_hi, exp_c, hi, lo;
        bit exp_err, seen;
        logic [W-1:0] exp_d;
        vmask = vmask | add;
        if (vmask == '0) vmask[$urandom_range(N - 1)] = 1'b1;
        who = -1;
        for (int k = 1; k <= N; k++)
            if (who < 0 && vmask[(last_m + k) % N]) who = (last_m + k) % N;
        last_m  = who;
        exp_d   = src_d[who];
        exp_err = rise > TO || fall > TO;
        exp_hi  = rise > TO ? TO + 1 : (rise < 1 ? 1 : rise);
        exp_c   = rise > TO ? TO + 3 : exp_hi + fall + 1;
        if (rise == 0) ack = 1'b1;
        drive();
        hi = 0;
        lo = 0;
        seen = 0;
        for (int c = 1; c <= 80 && !seen; c++) begin
            @(negedge clk);
            if (|src_done || |src_err) begin
                seen = 1;
                chk("pulse_cycle", c, exp_c);
                chk("done", src_done, exp_err ? '0 : onehot(who));
                chk("err", src_err, exp_err ? onehot(who) : '0);
                chk("req_high_cycles", hi, exp_hi);
                chk("idle_req", req, 0);
                chk("idle_busy", busy, 0);
                chk("data_hold", data, exp_d);
            end else if (req) begin
                hi++;
                if (hi == 1) begin
                    chk("req_rise_cycle", c, 1);
                    chk("data", data, exp_d);
                    chk("busy", busy, 1);
                end
                if (hi == rise) ack = 1'b1;
            end else if (hi > 0) begin
                lo++;
                if (lo == fall) ack = 1'b0;
            end
            if (c == 2 && mutate) begin
                src_d[who] = ~src_d[who];
                vmask[who] = 1'b0;
                drive();
            end
        end
        if (!seen) chk("pulse_timeout", 0, 1);
        if (!keep) vmask[who] = 1'b0;
        drive();
    endtask

    initial begin
        for (int i = 0; i < N; i++) src_d[i] = W'($urandom);
        drive();
        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data, 0);
        chk("rst_done", src_done, 0);
        chk("rst_err", src_err, 0);
        rst = 1'b0;
        src_d[2] = 8'hA5;
        run_txn(4'b0100, 3, 1, 0, 0);
        run_txn(4'b1000, 0, 2, 0, 0);
        run_txn(4'b0001, 999, 1, 0, 0);
        run_txn(4'b0100, 2, 20, 0, 0);
        run_txn(4'b0010, 3, 1, 1, 0);
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) if (!vmask[i]) src_d[i] = W'($urandom);
            run_txn(N'($urandom_range(0, 15)),
                    $urandom_range(0, 9) == 0 ? 999 : int'($urandom_range(0, TO)),
                    $urandom_range(0, 9) == 0 ? 20 : int'($urandom_range(1, TO)),
                    $urandom_range(0, 4) == 0, 0);
        end
        while (vmask != '0) run_txn('0, $urandom_range(1, 4), $urandom_range(1, 4), 0, 0);
        vmask = 4'b0100;
        src_d[2] = W'($urandom);
        drive();
        repeat (2) @(negedge clk);
        chk("pre_rst_req", req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", src_done, 0);
        chk("mid_rst_err", src_err, 0);
        chk("mid_rst_data", data, 0);
        rst = 1'b0;
        vmask = '0;
        last_m = N - 1;
        for (int t = 0; t < 5; t++) run_txn(4'b1111, 2, 1, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run expected finish before time limit");
        $fatal(1);
    end

endmodule
